// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: pipeline entry record and forward-select encodings.
// Entry addresses are stored at a fixed maximum width so the record type is independent of NREGS.
package hazard_scoreboard_pkg;

    localparam int SB_AW_MAX = 8;

    localparam int SEL_RF  = 0;
    localparam int SEL_EX  = 1;
    localparam int SEL_MEM = 2;
    localparam int SEL_WB  = 3;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic                 is_load;
        logic [SB_AW_MAX-1:0] wr_addr;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Finds the youngest in-flight writer of one source register.
// Purely combinational; no state and no flow control.
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int SW        = 2
) (
    input  sb_entry_t [DEPTH-1:0] entries_i,
    input  logic                  src_used_i,
    input  logic [SB_AW_MAX-1:0]  src_addr_i,
    output logic                  hit_o,
    output logic [SW-1:0]         sel_o,
    output logic                  load_hit_o
);

    // With a write-before-read register file the WB stage is already visible, so it never matches.
    localparam int NMATCH = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;

    always_comb begin
        hit_o      = 1'b0;
        sel_o      = '0;
        load_hit_o = 1'b0;
        for (int k = NMATCH - 1; k >= 0; k--) begin
            if (src_used_i && entries_i[k].valid && entries_i[k].wr_en &&
                (entries_i[k].wr_addr == src_addr_i)) begin
                hit_o      = 1'b1;
                sel_o      = SW'(k + 1);
                load_hit_o = (k == 0) && entries_i[k].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parameterised scoreboard producing stall and operand-forward selects for the ID stage.
// Outputs are combinational (zero latency); stall backpressures PC and IF_ID and bubbles ID_EX.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS     = 8,
    parameter int DEPTH     = 3,
    parameter int FORWARD   = 1,
    parameter int RF_BYPASS = 1,
    localparam int AW       = $clog2(NREGS),
    localparam int SW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_wr_addr,
    input  logic          id_is_load,
    input  logic          flush,
    output logic          stall,
    output logic          pc_write_en,
    output logic          if_id_write_en,
    output logic [SW-1:0] fwd_a_sel,
    output logic [SW-1:0] fwd_b_sel,
    output logic [15:0]   stall_count
);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [15:0]           stall_count_q, stall_count_d;

    logic          hit_a, hit_b, load_hit_a, load_hit_b, hazard;
    logic [SW-1:0] sel_a, sel_b;

    sb_match #(.DEPTH(DEPTH), .RF_BYPASS(RF_BYPASS), .SW(SW)) u_match_a (
        .entries_i  (entries_q),
        .src_used_i (id_rs_used),
        .src_addr_i (SB_AW_MAX'(id_rs_addr)),
        .hit_o      (hit_a),
        .sel_o      (sel_a),
        .load_hit_o (load_hit_a)
    );

    sb_match #(.DEPTH(DEPTH), .RF_BYPASS(RF_BYPASS), .SW(SW)) u_match_b (
        .entries_i  (entries_q),
        .src_used_i (id_rt_used),
        .src_addr_i (SB_AW_MAX'(id_rt_addr)),
        .hit_o      (hit_b),
        .sel_o      (sel_b),
        .load_hit_o (load_hit_b)
    );

    always_comb begin
        hazard = (FORWARD != 0) ? (load_hit_a | load_hit_b) : (hit_a | hit_b);
        // A flushed or empty ID slot never holds the front end.
        stall          = hazard & id_valid & ~flush;
        pc_write_en    = ~stall;
        if_id_write_en = ~stall;
        fwd_a_sel      = (FORWARD != 0) ? sel_a : SW'(SEL_RF);
        fwd_b_sel      = (FORWARD != 0) ? sel_b : SW'(SEL_RF);
        stall_count    = stall_count_q;
    end

    always_comb begin
        entries_d = '0;
        if (id_valid && !stall && !flush) begin
            entries_d[0].valid   = 1'b1;
            entries_d[0].wr_en   = id_wr_en;
            entries_d[0].is_load = id_is_load;
            entries_d[0].wr_addr = SB_AW_MAX'(id_wr_addr);
        end
        for (int k = 1; k < DEPTH; k++) begin
            entries_d[k] = entries_q[k-1];
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_q     <= '0;
            stall_count_q <= '0;
        end else begin
            entries_q     <= entries_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: forwarding instance driven by a vector table, stall-only instance by hand sequences.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
    logic [2:0] id_rs_addr, id_rt_addr, id_wr_addr;

    logic        stall1, pcw1, ifw1, stall2, pcw2, ifw2;
    logic [1:0]  fa1, fb1, fa2, fb2;
    logic [15:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.NREGS(8), .DEPTH(3), .FORWARD(1), .RF_BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .flush(flush), .stall(stall1), .pc_write_en(pcw1), .if_id_write_en(ifw1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_count(cnt1)
    );

    hazard_scoreboard #(.NREGS(8), .DEPTH(3), .FORWARD(0), .RF_BYPASS(1)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .flush(flush), .stall(stall2), .pc_write_en(pcw2), .if_id_write_en(ifw2),
        .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_count(cnt2)
    );

    typedef struct {
        logic       vld, rsu;
        logic [2:0] rs;
        logic       rtu;
        logic [2:0] rt;
        logic       we;
        logic [2:0] wa;
        logic       ld, fl, e_st;
        logic [1:0] e_a, e_b;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, rsu, input logic [2:0] rs, input logic rtu,
                         input logic [2:0] rt, input logic we, input logic [2:0] wa,
                         input logic ld, fl);
        id_valid = v; id_rs_used = rsu; id_rs_addr = rs; id_rt_used = rtu; id_rt_addr = rt;
        id_wr_en = we; id_wr_addr = wa; id_is_load = ld; flush = fl;
    endtask

    function automatic vec_t mk(input logic v, rsu, input logic [2:0] rs, input logic rtu,
                                input logic [2:0] rt, input logic we, input logic [2:0] wa,
                                input logic ld, fl, st, input logic [1:0] a, b,
                                input logic [15:0] cnt);
        vec_t r;
        r.vld = v; r.rsu = rsu; r.rs = rs; r.rtu = rtu; r.rt = rt; r.we = we; r.wa = wa;
        r.ld = ld; r.fl = fl; r.e_st = st; r.e_a = a; r.e_b = b; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            v rsu rs rtu rt we wa ld fl  st a  b  cnt
        tbl[0]  = mk(1, 1, 1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 3, 1, 4, 1, 6, 0, 0, 0, 1, 0, 0);
        tbl[2]  = mk(1, 1, 3, 1, 6, 1, 7, 0, 0, 0, 2, 1, 0);
        tbl[3]  = mk(1, 1, 3, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 7, 1, 2, 1, 5, 0, 0, 1, 0, 1, 0);
        tbl[6]  = mk(1, 1, 7, 1, 2, 1, 5, 0, 0, 0, 0, 2, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[8]  = mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1);
        tbl[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 0, 0, 1, 4, 1, 4, 0, 1, 0, 0, 1, 1);
        tbl[12] = mk(1, 0, 0, 1, 4, 1, 6, 1, 0, 0, 0, 2, 1);
        tbl[13] = mk(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[14] = mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 1);
        tbl[16] = mk(1, 1, 2, 1, 4, 0, 0, 0, 0, 1, 2, 1, 1);
        tbl[17] = mk(1, 1, 2, 1, 4, 0, 0, 0, 0, 0, 0, 2, 2);

        rst = 1'b0;
        drive(1, 1, 3, 1, 3, 1, 3, 1, 0);
        #3;
        chk("rst_stall1", stall1, 0);
        chk("rst_pcw1", pcw1, 1);
        chk("rst_ifw1", ifw1, 1);
        chk("rst_fa1", fa1, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_stall2", stall2, 0);
        chk("rst_cnt2", cnt2, 0);

        // Stall-only instance: writer then reader of R5 holds for EX and MEM, released by WB bypass.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
        tick();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        #1;
        chk("f0_stall_ex", stall2, 1);
        chk("f0_fa_ex", fa2, 0);
        chk("first_edge_capture_fa1", fa1, 1);
        tick();
        #1;
        chk("f0_stall_mem", stall2, 1);
        chk("f0_pcw_mem", pcw2, 0);
        tick();
        #1;
        chk("f0_stall_wb", stall2, 0);
        chk("f0_fa_wb", fa2, 0);
        tick();
        chk("f0_cnt", cnt2, 2);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].vld, tbl[i].rsu, tbl[i].rs, tbl[i].rtu, tbl[i].rt,
                  tbl[i].we, tbl[i].wa, tbl[i].ld, tbl[i].fl);
            #2;
            chk($sformatf("v%0d_stall", i), stall1, tbl[i].e_st);
            chk($sformatf("v%0d_pcw", i), {pcw1, ifw1}, {~tbl[i].e_st, ~tbl[i].e_st});
            chk($sformatf("v%0d_fa", i), fa1, tbl[i].e_a);
            chk($sformatf("v%0d_fb", i), fb1, tbl[i].e_b);
            chk($sformatf("v%0d_cnt", i), cnt1, tbl[i].e_cnt);
            tick();
        end

        // Reset asserted while a load-use stall is active clears everything at once.
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        #1;
        chk("midstall_pre", stall1, 1);
        rst = 1'b0;
        #1;
        chk("midstall_rst_stall", stall1, 0);
        chk("midstall_rst_pcw", pcw1, 1);
        chk("midstall_rst_cnt", cnt1, 0);
        @(negedge clk);
        rst = 1'b1;

        // Saturation: counter preloaded to all-ones must not wrap on a further stall.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut1.stall_count_q = 16'hFFFF;
        tick();
        release dut1.stall_count_q;
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
        #1;
        chk("sat_stall", stall1, 1);
        tick();
        chk("sat_cnt", cnt1, 16'hFFFF);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
